// File: rtl/int8_dual_mac_accum_if.sv
// Beat-in / result-out bundle for int8_dual_mac_accum.
// The master modport belongs to the producer/consumer side and the slave modport to the accumulator.
interface int8_dual_mac_accum_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 11
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [32:0]      in_p;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc_a;
  logic signed [ACC_W-1:0] out_acc_b;
  logic [CNT_W-1:0]        out_count;
  logic                    out_forced;
  logic                    out_sat;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_acc_a, out_acc_b, out_count, out_forced, out_sat
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_acc_a, out_acc_b, out_count, out_forced, out_sat
  );
endinterface

// File: rtl/int8_dual_mac_accum.sv
// Splits packed a*c / b*c DSP products into two lanes and accumulates one dot product per lane per vector.
// Optional INT8_ACC_SAT_EN: clamp each lane add and report clamping on out_sat (default build wraps).
module int8_dual_mac_accum #(
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  int8_dual_mac_accum_if.slave   mac_if
);

  logic signed [16:0] lane_ac;
  logic signed [15:0] lane_bc;
  logic [ACC_W-1:0]   ext_ac;
  logic [ACC_W-1:0]   ext_bc;
  logic [ACC_W-1:0]   sum_a;
  logic [ACC_W-1:0]   sum_b;
  logic               accept;
  logic               cnt_at_max;
  logic               vec_end;

  logic [ACC_W-1:0]   acc_a_q, acc_a_d;
  logic [ACC_W-1:0]   acc_b_q, acc_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   res_a_q, res_a_d;
  logic [ACC_W-1:0]   res_b_q, res_b_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               res_forced_q, res_forced_d;

`ifdef INT8_ACC_SAT_EN
  logic               sat_a;
  logic               sat_b;
  logic               beat_sat;
  logic               sat_flag_q, sat_flag_d;
  logic               res_sat_q, res_sat_d;

  // Returns {clamped, value}; overflow shows as disagreement of the two top bits of the widened sum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
    logic [ACC_W:0] w;
    w = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (w[ACC_W] != w[ACC_W-1]) begin
      if (w[ACC_W]) begin
        return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      return {1'b0, w[ACC_W-1:0]};
    end
  endfunction
`endif

  assign accept     = mac_if.in_valid && mac_if.in_ready;
  assign cnt_at_max = (cnt_q == CNT_W'(MAX_LEN - 1));
  assign vec_end    = accept && (mac_if.in_last || cnt_at_max);

  // Lane split: the lower product borrows one from the upper field when it is negative.
  always_comb begin
    lane_bc = $signed(mac_if.in_p[15:0]);
    lane_ac = $signed(mac_if.in_p[32:16]) + $signed({16'd0, mac_if.in_p[15]});
    ext_ac  = {{(ACC_W-17){lane_ac[16]}}, lane_ac};
    ext_bc  = {{(ACC_W-16){lane_bc[15]}}, lane_bc};
`ifdef INT8_ACC_SAT_EN
    {sat_a, sum_a} = sat_add(acc_a_q, ext_ac);
    {sat_b, sum_b} = sat_add(acc_b_q, ext_bc);
    beat_sat       = sat_a | sat_b;
`else
    sum_a = acc_a_q + ext_ac;
    sum_b = acc_b_q + ext_bc;
`endif
  end

  // Next state for accumulators, beat counter and result registers.
  always_comb begin
    acc_a_d      = acc_a_q;
    acc_b_d      = acc_b_q;
    cnt_d        = cnt_q;
    res_a_d      = res_a_q;
    res_b_d      = res_b_q;
    res_cnt_d    = res_cnt_q;
    res_forced_d = res_forced_q;
    out_valid_d  = out_valid_q;
`ifdef INT8_ACC_SAT_EN
    sat_flag_d   = sat_flag_q;
    res_sat_d    = res_sat_q;
`endif
    if (out_valid_q && mac_if.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (vec_end) begin
      res_a_d      = sum_a;
      res_b_d      = sum_b;
      res_cnt_d    = cnt_q + CNT_W'(1);
      res_forced_d = !mac_if.in_last && cnt_at_max;
      out_valid_d  = 1'b1;
      acc_a_d      = {ACC_W{1'b0}};
      acc_b_d      = {ACC_W{1'b0}};
      cnt_d        = {CNT_W{1'b0}};
`ifdef INT8_ACC_SAT_EN
      res_sat_d    = sat_flag_q | beat_sat;
      sat_flag_d   = 1'b0;
`endif
    end else if (accept) begin
      acc_a_d      = sum_a;
      acc_b_d      = sum_b;
      cnt_d        = cnt_q + CNT_W'(1);
`ifdef INT8_ACC_SAT_EN
      sat_flag_d   = sat_flag_q | beat_sat;
`endif
    end else begin
      cnt_d        = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_a_q      <= {ACC_W{1'b0}};
      acc_b_q      <= {ACC_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      out_valid_q  <= 1'b0;
      res_a_q      <= {ACC_W{1'b0}};
      res_b_q      <= {ACC_W{1'b0}};
      res_cnt_q    <= {CNT_W{1'b0}};
      res_forced_q <= 1'b0;
`ifdef INT8_ACC_SAT_EN
      sat_flag_q   <= 1'b0;
      res_sat_q    <= 1'b0;
`endif
    end else begin
      acc_a_q      <= acc_a_d;
      acc_b_q      <= acc_b_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      res_a_q      <= res_a_d;
      res_b_q      <= res_b_d;
      res_cnt_q    <= res_cnt_d;
      res_forced_q <= res_forced_d;
`ifdef INT8_ACC_SAT_EN
      sat_flag_q   <= sat_flag_d;
      res_sat_q    <= res_sat_d;
`endif
    end
  end

  assign mac_if.in_ready   = !out_valid_q || mac_if.out_ready;
  assign mac_if.out_valid  = out_valid_q;
  assign mac_if.out_acc_a  = res_a_q;
  assign mac_if.out_acc_b  = res_b_q;
  assign mac_if.out_count  = res_cnt_q;
  assign mac_if.out_forced = res_forced_q;
`ifdef INT8_ACC_SAT_EN
  assign mac_if.out_sat    = res_sat_q;
`else
  assign mac_if.out_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_int8_dual_mac_accum.sv
// Scoreboard bench for int8_dual_mac_accum with ACC_W=18, MAX_LEN=8 so forced ends and lane overflow are reachable.
module tb_int8_dual_mac_accum;
  localparam int ACC_W   = 18;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;

  typedef struct {
    longint a;
    longint b;
    int     cnt;
    bit     forced;
    bit     sat;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  bit   rnd_done;

  longint m_a, m_b;
  int     m_cnt;
  bit     m_sat;

  always #5 clk = ~clk;

  int8_dual_mac_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) mac_if ();

  int8_dual_mac_accum #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .mac_if (mac_if)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint lane_add(input longint acc, input longint lane, output bit clamped);
    longint v, lo, hi;
    logic signed [ACC_W-1:0] t;
    v  = acc + lane;
    lo = -(longint'(1) <<< (ACC_W - 1));
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    clamped = 1'b0;
`ifdef INT8_ACC_SAT_EN
    if (v > hi) begin clamped = 1'b1; return hi; end
    if (v < lo) begin clamped = 1'b1; return lo; end
    return v;
`else
    t = v[ACC_W-1:0];
    return longint'(t);
`endif
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_cnt = 0; m_sat = 1'b0;
  endtask

  task automatic model_beat(input int a, input int b, input int c, input bit last);
    bit sa, sb, ends;
    longint na, nb;
    res_t r;
    na   = lane_add(m_a, longint'(a * c), sa);
    nb   = lane_add(m_b, longint'(b * c), sb);
    ends = last || (m_cnt == MAX_LEN - 1);
    if (ends) begin
      r.a = na; r.b = nb; r.cnt = m_cnt + 1;
      r.forced = !last && (m_cnt == MAX_LEN - 1);
      r.sat = m_sat | sa | sb;
      exp_q.push_back(r);
      model_reset();
    end else begin
      m_a = na; m_b = nb; m_cnt++; m_sat = m_sat | sa | sb;
    end
  endtask

  // Drive one beat from posedge+1; acceptance is judged from in_ready at the preceding negedge.
  task automatic send(input int a, input int b, input int c, input bit last);
    longint p;
    bit ok;
    int n;
    p = longint'(a * c) * 65536 + longint'(b * c);
    mac_if.in_p     = p[32:0];
    mac_if.in_last  = last;
    mac_if.in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = mac_if.in_ready;
      n++;
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    else model_beat(a, b, c, last);
    @(posedge clk); #1;
    mac_if.in_valid = 1'b0;
    mac_if.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: every result handed over is checked against the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (!rst && mac_if.out_valid && mac_if.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("acc_a",  longint'(mac_if.out_acc_a), e.a);
        chk("acc_b",  longint'(mac_if.out_acc_b), e.b);
        chk("count",  longint'(mac_if.out_count), longint'(e.cnt));
        chk("forced", longint'(mac_if.out_forced), longint'(e.forced));
        chk("sat",    longint'(mac_if.out_sat), longint'(e.sat));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    mac_if.in_valid  = 1'b0;
    mac_if.in_p      = 33'sd0;
    mac_if.in_last   = 1'b0;
    mac_if.out_ready = 1'b1;
    rnd_done = 1'b0;
    model_reset();
    idle(2);
    chk("rst_out_valid", longint'(mac_if.out_valid), 0);
    chk("rst_in_ready",  longint'(mac_if.in_ready), 1);
    chk("rst_acc_a",     longint'(mac_if.out_acc_a), 0);
    chk("rst_count",     longint'(mac_if.out_count), 0);
    rst = 1'b0;
    idle(1);

    // single split, then signed extremes
    send(3, -2, 5, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) send(255, -128, -128, i == 3);
    idle(2);

    // forced end after MAX_LEN beats; two leftovers plus one ending beat form the next vector
    for (int i = 0; i < 10; i++) send(1, 1, 1, 1'b0);
    send(1, 1, 1, 1'b1);
    // in_last right after a forced end is a fresh one-beat vector
    for (int i = 0; i < 8; i++) send(1, 1, 1, 1'b0);
    send(2, 3, 1, 1'b1);
    // exactly MAX_LEN beats ended by in_last is not forced
    for (int i = 0; i < 8; i++) send(1, -1, 2, i == 7);
    idle(2);

    // lane A overflow: clamps or wraps depending on build
    for (int i = 0; i < 5; i++) send(255, 0, 127, i == 4);
    idle(2);

    // backpressure with the next ending beat waiting
    mac_if.out_ready = 1'b0;
    send(2, 1, 3, 1'b1);
    fork
      send(4, -1, 2, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready",  longint'(mac_if.in_ready), 0);
          chk("bp_out_valid", longint'(mac_if.out_valid), 1);
          chk("bp_acc_a",     longint'(mac_if.out_acc_a), 6);
          chk("bp_acc_b",     longint'(mac_if.out_acc_b), 3);
        end
        @(posedge clk); #1;
        mac_if.out_ready = 1'b1;
      end
    join
    idle(3);

    // reset mid-vector discards the partial sums
    for (int i = 0; i < 3; i++) send(5, 5, 5, 1'b0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_in_ready", longint'(mac_if.in_ready), 1);
    idle(2);
    chk("midrst_out_valid", longint'(mac_if.out_valid), 0);
    rst = 1'b0;
    idle(1);
    send(2, 1, 1, 1'b0);
    send(2, 1, 1, 1'b1);
    idle(2);

    // random vectors under random consumer stalls
    fork
      begin
        for (int v = 0; v < 25; v++) begin
          int len;
          len = $urandom_range(1, 10);
          for (int k = 0; k < len; k++) begin
            send($urandom_range(0, 255), int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128, k == len - 1);
            if ($urandom_range(0, 3) == 0) idle(1);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          mac_if.out_ready = ($urandom_range(0, 2) != 0);
        end
        mac_if.out_ready = 1'b1;
      end
    join
    idle(4);
    chk("queue_empty", longint'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
